apu_mixer: RTL and testbench

APU_MIXER -- requirements
Module: apu_mixer

---
 rtl/apu_mix_pkg.sv | 37 +++
 rtl/apu_dac.sv | 21 ++
 rtl/apu_mixer.sv | 137 +++++++++++++
 tb/tb_apu_mixer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/apu_mix_pkg.sv
// apu_mix_pkg: shared types and register bit positions for the APU sound mixer.
//   dac_t : signed DAC level of one channel (-15..+15)
//   sum_t : signed per-side channel sum (-60..+60)
//   mix_t : signed scaled output sample (-480..+480)
package apu_mix_pkg;

    typedef logic signed [4:0] dac_t;
    typedef logic signed [6:0] sum_t;
    typedef logic signed [9:0] mix_t;

    // NR50 (master volume / VIN routing)
    localparam int NR50_VIN_L     = 7;
    localparam int NR50_VOL_L_MSB = 6;
    localparam int NR50_VOL_L_LSB = 4;
    localparam int NR50_VIN_R     = 3;
    localparam int NR50_VOL_R_MSB = 2;
    localparam int NR50_VOL_R_LSB = 0;

    // NR51 (per-channel panning): channel i goes left via bit LEFT_LSB+i,
    // right via bit RIGHT_LSB+i
    localparam int NR51_LEFT_LSB  = 4;
    localparam int NR51_RIGHT_LSB = 0;

    // Clocks from sample_tick to mix_valid
    localparam int PIPE_LAT = 3;

    // Scale a side sum by its master volume field (0..7 means x1..x8).
    function automatic mix_t scale_sum(input sum_t s, input logic [2:0] vol);
        mix_t sx;
        mix_t mult;
        sx   = {{3{s[6]}}, s};
        mult = {7'b0, vol};
        mult = mult + 10'sd1;
        return sx * mult;
    endfunction

endpackage

// File: rtl/apu_dac.sv
// apu_dac: converts one 4-bit channel amplitude to a signed DAC level.
//   code    : 4-bit digital amplitude (0..15)
//   dac_off : high = DAC powered off, level forced to 0
//   level   : signed 2*code-15 (-15..+15), or 0 when off
module apu_dac
    import apu_mix_pkg::*;
(
    input  logic [3:0] code,
    input  logic       dac_off,
    output dac_t       level
);

    // 2*code-15 == {code,1} - 16 in 5 bits, i.e. {code,1} with the MSB inverted.
    always_comb begin
        level = '0;
        if (!dac_off) begin
            level = {~code[3], code[2:0], 1'b1};
        end
    end

endmodule

// File: rtl/apu_mixer.sv
// apu_mixer: NR50/NR51 registers and a 3-stage stereo mixing pipeline.
//   amuk_4mhz   : clock, all state on rising edge
//   apu_reset   : synchronous active-high reset
//   d           : CPU write data
//   nff24_wr    : active-low NR50 write strobe
//   nff25_wr    : active-low NR51 write strobe
//   ch_out      : per-channel 4-bit amplitude
//   nch_amp_en  : per-channel DAC-off flag (high = off)
//   sample_tick : request one mix sample
//   ff24_q      : NR50 readback
//   ff25_q      : NR51 readback
//   vin_l_en    : live NR50 bit 7
//   vin_r_en    : live NR50 bit 3
//   mix_l/mix_r : signed mixed sample, held between strobes
//   mix_valid   : one-cycle strobe, PIPE_LAT cycles after sample_tick
module apu_mixer
    import apu_mix_pkg::*;
#(
    parameter int NCH = 4
) (
    input  logic                amuk_4mhz,
    input  logic                apu_reset,
    input  logic [7:0]          d,
    input  logic                nff24_wr,
    input  logic                nff25_wr,
    input  logic [NCH-1:0][3:0] ch_out,
    input  logic [NCH-1:0]      nch_amp_en,
    input  logic                sample_tick,
    output logic [7:0]          ff24_q,
    output logic [7:0]          ff25_q,
    output logic                vin_l_en,
    output logic                vin_r_en,
    output mix_t                mix_l,
    output mix_t                mix_r,
    output logic                mix_valid
);

    logic [7:0] nr50_q, nr51_q;

    // Stage 1: DAC levels and register snapshots
    dac_t       dac_lvl  [NCH];
    dac_t       dac_s1_q [NCH];
    logic [2:0] vol_l_s1_q, vol_r_s1_q;
    logic [7:0] nr51_s1_q;
    logic       v1_q;

    // Stage 2: panned sums
    sum_t       sum_l_d, sum_r_d;
    sum_t       sum_l_s2_q, sum_r_s2_q;
    logic [2:0] vol_l_s2_q, vol_r_s2_q;
    logic       v2_q;

    // Stage 3: scaled output
    mix_t       mix_l_q, mix_r_q;
    logic       mix_valid_q;

    for (genvar g = 0; g < NCH; g++) begin : g_dac
        apu_dac u_dac (
            .code    (ch_out[g]),
            .dac_off (nch_amp_en[g]),
            .level   (dac_lvl[g])
        );
    end

    always_comb begin
        sum_l_d = '0;
        sum_r_d = '0;
        for (int i = 0; i < NCH; i++) begin
            if (nr51_s1_q[NR51_LEFT_LSB + i]) begin
                sum_l_d = sum_l_d + {{2{dac_s1_q[i][4]}}, dac_s1_q[i]};
            end
            if (nr51_s1_q[NR51_RIGHT_LSB + i]) begin
                sum_r_d = sum_r_d + {{2{dac_s1_q[i][4]}}, dac_s1_q[i]};
            end
        end
    end

    always_ff @(posedge amuk_4mhz) begin
        if (apu_reset) begin
            nr50_q      <= '0;
            nr51_q      <= '0;
            for (int i = 0; i < NCH; i++) begin
                dac_s1_q[i] <= '0;
            end
            vol_l_s1_q  <= '0;
            vol_r_s1_q  <= '0;
            nr51_s1_q   <= '0;
            v1_q        <= 1'b0;
            sum_l_s2_q  <= '0;
            sum_r_s2_q  <= '0;
            vol_l_s2_q  <= '0;
            vol_r_s2_q  <= '0;
            v2_q        <= 1'b0;
            mix_l_q     <= '0;
            mix_r_q     <= '0;
            mix_valid_q <= 1'b0;
        end else begin
            if (!nff24_wr) nr50_q <= d;
            if (!nff25_wr) nr51_q <= d;

            // Snapshot reads the register before this edge, so a colliding
            // write only affects later samples.
            v1_q <= sample_tick;
            if (sample_tick) begin
                for (int i = 0; i < NCH; i++) begin
                    dac_s1_q[i] <= dac_lvl[i];
                end
                vol_l_s1_q <= nr50_q[NR50_VOL_L_MSB:NR50_VOL_L_LSB];
                vol_r_s1_q <= nr50_q[NR50_VOL_R_MSB:NR50_VOL_R_LSB];
                nr51_s1_q  <= nr51_q;
            end

            v2_q <= v1_q;
            if (v1_q) begin
                sum_l_s2_q <= sum_l_d;
                sum_r_s2_q <= sum_r_d;
                vol_l_s2_q <= vol_l_s1_q;
                vol_r_s2_q <= vol_r_s1_q;
            end

            mix_valid_q <= v2_q;
            if (v2_q) begin
                mix_l_q <= scale_sum(sum_l_s2_q, vol_l_s2_q);
                mix_r_q <= scale_sum(sum_r_s2_q, vol_r_s2_q);
            end
        end
    end

    assign ff24_q    = nr50_q;
    assign ff25_q    = nr51_q;
    assign vin_l_en  = nr50_q[NR50_VIN_L];
    assign vin_r_en  = nr50_q[NR50_VIN_R];
    assign mix_l     = mix_l_q;
    assign mix_r     = mix_r_q;
    assign mix_valid = mix_valid_q;

endmodule

// File: tb/tb_apu_mixer.sv
// tb_apu_mixer: directed self-checking bench for apu_mixer.
module tb_apu_mixer;

    logic              clk = 1'b0;
    logic              apu_reset;
    logic [7:0]        d;
    logic              nff24_wr, nff25_wr;
    logic [3:0][3:0]   ch_out;
    logic [3:0]        nch_amp_en;
    logic              sample_tick;
    logic [7:0]        ff24_q, ff25_q;
    logic              vin_l_en, vin_r_en;
    logic signed [9:0] mix_l, mix_r;
    logic              mix_valid;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    apu_mixer #(.NCH(4)) dut (
        .amuk_4mhz   (clk),
        .apu_reset   (apu_reset),
        .d           (d),
        .nff24_wr    (nff24_wr),
        .nff25_wr    (nff25_wr),
        .ch_out      (ch_out),
        .nch_amp_en  (nch_amp_en),
        .sample_tick (sample_tick),
        .ff24_q      (ff24_q),
        .ff25_q      (ff25_q),
        .vin_l_en    (vin_l_en),
        .vin_r_en    (vin_r_en),
        .mix_l       (mix_l),
        .mix_r       (mix_r),
        .mix_valid   (mix_valid)
    );

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic wr50(input logic [7:0] v);
        d = v; nff24_wr = 1'b0;
        step();
        nff24_wr = 1'b1;
    endtask

    task automatic wr51(input logic [7:0] v);
        d = v; nff25_wr = 1'b0;
        step();
        nff25_wr = 1'b1;
    endtask

    // Tick, then check valid is low before and high exactly on the third edge.
    task automatic tick_check(input string tag, input int exp_l, input int exp_r);
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step();
        chk({tag, "_early"}, 32'(mix_valid), 0);
        step();
        chk({tag, "_valid"}, 32'(mix_valid), 1);
        chk({tag, "_l"}, mix_l, exp_l);
        chk({tag, "_r"}, mix_r, exp_r);
    endtask

    logic [15:0] seq_vec [4];
    int          seq_l   [4];
    int          seq_r   [4];

    initial begin
        apu_reset = 1'b1; d = '0; nff24_wr = 1'b1; nff25_wr = 1'b1;
        ch_out = '0; nch_amp_en = '0; sample_tick = 1'b0;
        step(); step();
        chk("rst_ff24", ff24_q, 0);
        chk("rst_ff25", ff25_q, 0);
        chk("rst_valid", 32'(mix_valid), 0);
        chk("rst_mix_l", mix_l, 0);
        chk("rst_mix_r", mix_r, 0);
        apu_reset = 1'b0;
        step();

        // VIN bits follow the live register
        wr50(8'h80);
        chk("ff24_80", ff24_q, 8'h80);
        chk("vin_l_80", 32'(vin_l_en), 1);
        chk("vin_r_80", 32'(vin_r_en), 0);
        wr50(8'h08);
        chk("vin_l_08", 32'(vin_l_en), 0);
        chk("vin_r_08", 32'(vin_r_en), 1);

        // Full left pan at max volume: 4*15*8
        ch_out = 16'hFFFF; nch_amp_en = 4'h0;
        wr51(8'hF0);
        wr50(8'h77);
        chk("ff25_f0", ff25_q, 8'hF0);
        tick_check("pan", 480, 0);
        step();
        chk("pan_strobe_end", 32'(mix_valid), 0);
        chk("pan_hold_l", mix_l, 480);

        // Routing: ch0=-15, ch1=+15
        ch_out = 16'hF0F0;
        wr51(8'h33);
        wr50(8'h00);
        tick_check("route33", 0, 0);
        wr51(8'h11);
        tick_check("route11", -15, -15);

        // DAC off and negative extreme
        nch_amp_en = 4'hF;
        wr51(8'hFF);
        wr50(8'h77);
        tick_check("dacoff", 0, 0);
        nch_amp_en = 4'h0; ch_out = 16'h0000;
        tick_check("negmax", -480, -480);

        // Write colliding with tick: sample sees old NR50 (x1)
        ch_out = 16'hFFFF;
        wr50(8'h00);
        d = 8'h70; nff24_wr = 1'b0; sample_tick = 1'b1;
        step();
        nff24_wr = 1'b1; sample_tick = 1'b0;
        step(); step();
        chk("coll_valid", 32'(mix_valid), 1);
        chk("coll_l", mix_l, 60);
        chk("coll_r", mix_r, 60);
        tick_check("after_coll", 480, 60);

        // Back-to-back ticks, L x3 / R x6, NR51=A5
        seq_vec[0] = 16'h4321; seq_l[0] = -54; seq_r[0] = -132;
        seq_vec[1] = 16'hCDEF; seq_l[1] = 66;  seq_r[1] = 156;
        seq_vec[2] = 16'hA978; seq_l[2] = 12;  seq_r[2] = 24;
        seq_vec[3] = 16'h6CF0; seq_l[3] = 36;  seq_r[3] = -36;
        wr50(8'h25);
        wr51(8'hA5);
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                ch_out = seq_vec[k]; sample_tick = 1'b1;
            end else begin
                sample_tick = 1'b0;
            end
            step();
            if (k >= 2) begin
                chk($sformatf("seq%0d_valid", k - 2), 32'(mix_valid), 1);
                chk($sformatf("seq%0d_l", k - 2), mix_l, seq_l[k - 2]);
                chk($sformatf("seq%0d_r", k - 2), mix_r, seq_r[k - 2]);
            end
        end
        step();
        chk("seq_end", 32'(mix_valid), 0);

        // Reset one cycle after tick discards the sample
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0; apu_reset = 1'b1;
        step();
        apu_reset = 1'b0;
        chk("midrst_ff24", ff24_q, 0);
        chk("midrst_ff25", ff25_q, 0);
        chk("midrst_l", mix_l, 0);
        chk("midrst_r", mix_r, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("midrst_novalid%0d", k), 32'(mix_valid), 0);
        end

        // Writes and ticks during reset are ignored
        apu_reset = 1'b1; d = 8'hFF; nff24_wr = 1'b0; nff25_wr = 1'b0; sample_tick = 1'b1;
        step();
        apu_reset = 1'b0; nff24_wr = 1'b1; nff25_wr = 1'b1; sample_tick = 1'b0;
        chk("rstwr_ff24", ff24_q, 0);
        chk("rstwr_ff25", ff25_q, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("rsttick_novalid%0d", k), 32'(mix_valid), 0);
        end

        // First tick after reset: NR51 cleared, so silence
        ch_out = 16'hFFFF; nch_amp_en = 4'h0;
        tick_check("post_rst", 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
